mem_bus_arbiter: RTL and testbench

- Shares the single 8-bit synchronous memory bus between two masters: m0 is the CPU core, m1 is the DMA/video fetcher.
- Each master issues byte or little-endian word transfers through a req/ack handshake.
- The arbiter picks a grantee, splits word transfers into two byte cycles, gathers read data and returns one ack pulse.
- It sits between the masters and the top-level memory pins (address/data/out/wren).

---
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master arbiter for an 8-bit synchronous memory bus. Word
//            transfers are split into two byte cycles and acknowledged once.
//            Define MEM_BUS_ARBITER_LOCK_EN to add the m0_lock input.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW         = 20,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic          m0_w16,
    input  logic [15:0]   m0_wdata,
`ifdef MEM_BUS_ARBITER_LOCK_EN
    input  logic          m0_lock,
`endif
    output logic          m0_ack,
    output logic [15:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic          m1_w16,
    input  logic [15:0]   m1_wdata,
    output logic          m1_ack,
    output logic [15:0]   m1_rdata,
    output logic [AW-1:0] mem_address,
    input  logic [7:0]    mem_data,
    output logic [7:0]    mem_out,
    output logic          mem_wren,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A0   = 3'd1,
        S_A1   = 3'd2,
        S_A2   = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t        state_q;
    logic          gnt_m1_q;
    logic          last_m1_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          w16_q;
    logic [7:0]    whi_q;
    logic [7:0]    rlo_q;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic          lock_q;
`endif

    logic          gnt_m1_d;
    logic [AW-1:0] addr_d;
    logic          we_d;
    logic          w16_d;
    logic [15:0]   wdata_d;

    always_comb begin
        if (m0_req && m1_req) begin
            gnt_m1_d = (FIXED_PRIO != 1'b0) ? 1'b0 : ~last_m1_q;
        end else begin
            gnt_m1_d = m1_req;
        end
`ifdef MEM_BUS_ARBITER_LOCK_EN
        // A locked m0 sequence keeps the bus regardless of m1 or rotation.
        if (lock_q && m0_req) begin
            gnt_m1_d = 1'b0;
        end
`endif
        addr_d  = gnt_m1_d ? m1_addr  : m0_addr;
        we_d    = gnt_m1_d ? m1_we    : m0_we;
        w16_d   = gnt_m1_d ? m1_w16   : m0_w16;
        wdata_d = gnt_m1_d ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_m1_q    <= 1'b0;
            last_m1_q   <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            w16_q       <= 1'b0;
            whi_q       <= 8'h00;
            rlo_q       <= 8'h00;
            mem_address <= '0;
            mem_out     <= 8'h00;
            mem_wren    <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= 16'h0000;
            m1_rdata    <= 16'h0000;
            busy        <= 1'b0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_wren <= 1'b0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
                    if (!m0_req) begin
                        lock_q <= 1'b0;
                    end
`endif
                    if (m0_req || m1_req) begin
                        gnt_m1_q    <= gnt_m1_d;
                        addr_q      <= addr_d;
                        we_q        <= we_d;
                        w16_q       <= w16_d;
                        whi_q       <= wdata_d[15:8];
                        mem_address <= addr_d;
                        mem_out     <= wdata_d[7:0];
                        mem_wren    <= we_d;
                        busy        <= 1'b1;
                        state_q     <= S_A0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
                        if (!gnt_m1_d) begin
                            lock_q <= m0_lock;
                        end
`endif
                    end
                end
                S_A0: begin
                    if (w16_q) begin
                        mem_address <= addr_q + AW'(1);
                        mem_out     <= whi_q;
                    end else begin
                        mem_wren <= 1'b0;
                    end
                    state_q <= S_A1;
                end
                S_A1: begin
                    mem_wren <= 1'b0;
                    if (w16_q) begin
                        rlo_q   <= mem_data;
                        state_q <= S_A2;
                    end else begin
                        // Writes leave the previous read data untouched.
                        if (!we_q) begin
                            if (gnt_m1_q) begin
                                m1_rdata <= {8'h00, mem_data};
                            end else begin
                                m0_rdata <= {8'h00, mem_data};
                            end
                        end
                        m0_ack  <= ~gnt_m1_q;
                        m1_ack  <= gnt_m1_q;
                        state_q <= S_ACK;
                    end
                end
                S_A2: begin
                    if (!we_q) begin
                        if (gnt_m1_q) begin
                            m1_rdata <= {mem_data, rlo_q};
                        end else begin
                            m0_rdata <= {mem_data, rlo_q};
                        end
                    end
                    m0_ack  <= ~gnt_m1_q;
                    m1_ack  <= gnt_m1_q;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    last_m1_q <= gnt_m1_q;
                    busy      <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    mem_wren <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Scoreboard bench for mem_bus_arbiter against a transaction-level
//            model of grant order, memory contents and ack timing.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW         = 20;
    localparam bit FIXED_PRIO = 1'b0;

    typedef struct packed {
        logic [19:0] a;
        logic        we;
        logic        w16;
        logic        lk;
        logic [15:0] wd;
    } txn_t;

    typedef struct {
        int          who;
        logic [15:0] rd;
        int          cyc;
        int          wren;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_w16 = 1'b0;
    logic [19:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_w16 = 1'b0;
    logic [19:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic        m0_lock = 1'b0;
`endif
    logic        m0_ack, m1_ack, mem_wren, busy;
    logic [15:0] m0_rdata, m1_rdata;
    logic [19:0] mem_address;
    logic [7:0]  mem_out;
    logic [7:0]  mem_data;

    logic [7:0]  pmem [0:(1<<AW)-1];
    logic        bd_en = 1'b0;
    logic [19:0] bd_addr = '0;
    logic [7:0]  bd_val = '0;

    logic [7:0]  ref_mem [logic [19:0]];
    logic [15:0] last_rd [2];
    int          ref_last = 1;
    bit          ref_lock = 1'b0;
    exp_t        sbq [$];
    int          cyc = 0, checks = 0, errors = 0, wcnt = 0;

    mem_bus_arbiter #(.AW(AW), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_w16(m0_w16),
        .m0_wdata(m0_wdata),
`ifdef MEM_BUS_ARBITER_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_w16(m1_w16),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_out(mem_out),
        .mem_wren(mem_wren), .busy(busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Synchronous byte memory: read data appears one cycle after the address.
    always @(posedge clock) begin
        mem_data <= pmem[mem_address];
        if (bd_en) pmem[bd_addr] <= bd_val;
        else if (mem_wren) pmem[mem_address] <= mem_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int lat(input txn_t t);
        return t.w16 ? 4 : 3;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.a   = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 + 20'($urandom_range(0, 15)))
                                            : 20'($urandom_range(0, 47));
        t.we  = 1'($urandom_range(0, 1));
        t.w16 = 1'($urandom_range(0, 1));
        t.wd  = 16'($urandom);
`ifdef MEM_BUS_ARBITER_LOCK_EN
        t.lk  = 1'($urandom_range(0, 1));
`else
        t.lk  = 1'b0;
`endif
        return t;
    endfunction

    task automatic preset(input logic [19:0] a, input logic [7:0] v);
        @(negedge clock);
        bd_en = 1'b1; bd_addr = a; bd_val = v;
        ref_mem[a] = v;
    endtask

    // Transaction-level effect of one granted transfer.
    task automatic model_xfer(input int who, input txn_t t, input int ackc);
        exp_t e;
        logic [19:0] a1;
        a1 = t.a + 20'd1;
        if (t.we) begin
            ref_mem[t.a] = t.wd[7:0];
            if (t.w16) ref_mem[a1] = t.wd[15:8];
        end else begin
            last_rd[who] = {t.w16 ? ref_rd(a1) : 8'h00, ref_rd(t.a)};
        end
        e.who  = who;
        e.rd   = last_rd[who];
        e.cyc  = ackc;
        e.wren = t.we ? (t.w16 ? 2 : 1) : 0;
        if (who == 0) ref_lock = t.lk;
        ref_last = who;
        sbq.push_back(e);
    endtask

    task automatic drive(input int who, input txn_t t);
        if (who == 0) begin
            m0_addr = t.a; m0_we = t.we; m0_w16 = t.w16; m0_wdata = t.wd;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            m0_lock = t.lk;
`endif
        end else begin
            m1_addr = t.a; m1_we = t.we; m1_w16 = t.w16; m1_wdata = t.wd;
        end
    endtask

    task automatic round(input bit u0, input bit u1, input txn_t t0, input txn_t t1, input int gap);
        int n, first, second, e1;
        bit d0, d1;
        txn_t tf, ts;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        n = cyc;
        if (gap > 0 || !u0) ref_lock = 1'b0;
        if (u0) drive(0, t0);
        if (u1) drive(1, t1);
        m0_req = u0;
        m1_req = u1;
        if (u0 && u1) first = (ref_lock || FIXED_PRIO) ? 0 : ((ref_last == 1) ? 0 : 1);
        else first = u1 ? 1 : 0;
        tf = (first == 1) ? t1 : t0;
        e1 = n + lat(tf);
        model_xfer(first, tf, e1);
        if (u0 && u1) begin
            second = 1 - first;
            ts = (second == 1) ? t1 : t0;
            if (second == 1) ref_lock = 1'b0;
            model_xfer(second, ts, e1 + 1 + lat(ts));
        end
        d0 = !u0;
        d1 = !u1;
        for (int k = 0; k < 40 && !(d0 && d1); k++) begin
            @(negedge clock);
            if (k == 0) begin
                chk("grant_addr", 32'(mem_address), 32'(tf.a));
                chk("busy_active", 32'(busy), 32'd1);
                drive(first, rand_txn());
            end
            if (m0_ack && !d0) begin m0_req = 1'b0; d0 = 1'b1; end
            if (m1_ack && !d1) begin m1_req = 1'b0; d1 = 1'b1; end
        end
        if (!(d0 && d1)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after 40 cycles expected ack (cycle %0d)", cyc);
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    task automatic reset_mid();
        txn_t t;
        t = '0;
        t.a = 20'h00020; t.we = 1'b1; t.w16 = 1'b1; t.wd = 16'h5AC3;
        @(negedge clock);
        drive(0, t);
        m0_req = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_wren_async", 32'(mem_wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_no_ack", 32'(m0_ack), 32'd0);
        m0_req = 1'b0;
        ref_mem[t.a] = t.wd[7:0];
        ref_last = 1;
        ref_lock = 1'b0;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_m0_rdata", 32'(m0_rdata), 32'd0);
    endtask

    // Monitor: every ack pops the oldest expected transfer.
    initial forever begin
        exp_t e;
        int who;
        @(negedge clock);
        if (reset) begin
            wcnt = 0;
        end else begin
            if (mem_wren) wcnt++;
            if (m0_ack || m1_ack) begin
                if (m0_ack && m1_ack) begin
                    chk("dual_ack", 32'd1, 32'd0);
                end else if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    who = m1_ack ? 1 : 0;
                    chk("ack_master", 32'(who), 32'(e.who));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rdata", 32'((who == 1) ? m1_rdata : m0_rdata), 32'(e.rd));
                    chk("wren_cycles", 32'(wcnt), 32'(e.wren));
                end
                wcnt = 0;
            end
        end
    end

    initial begin
        txn_t ta, tb, tz;
        tz = '0;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        repeat (3) @(negedge clock);
        chk("reset_mem_address", 32'(mem_address), 32'd0);
        chk("reset_mem_out", 32'(mem_out), 32'd0);
        chk("reset_mem_wren", 32'(mem_wren), 32'd0);
        chk("reset_m0_ack", 32'(m0_ack), 32'd0);
        chk("reset_m1_ack", 32'(m1_ack), 32'd0);
        chk("reset_m0_rdata", 32'(m0_rdata), 32'd0);
        chk("reset_m1_rdata", 32'(m1_rdata), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 64; i++) preset(20'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) preset(20'hFFFF0 + 20'(i), 8'($urandom));
        preset(20'h12345, 8'hA5);
        preset(20'h00010, 8'h34);
        preset(20'h00011, 8'h12);
        @(negedge clock);
        bd_en = 1'b0;
        reset = 1'b0;

        ta = '0; ta.a = 20'h12345;
        round(1'b1, 1'b0, ta, tz, 1);
        tb = '0; tb.a = 20'hFFFFF; tb.we = 1'b1; tb.w16 = 1'b1; tb.wd = 16'hBEEF;
        round(1'b0, 1'b1, tz, tb, 1);
        ta = '0; ta.a = 20'hFFFFF; ta.w16 = 1'b1;
        round(1'b1, 1'b0, ta, tz, 0);
        ta = '0; ta.a = 20'h00010; ta.w16 = 1'b1;
        round(1'b1, 1'b0, ta, tz, 2);
        for (int i = 0; i < 3; i++) round(1'b1, 1'b1, rand_txn(), rand_txn(), 0);

`ifdef MEM_BUS_ARBITER_LOCK_EN
        ta = '0; ta.a = 20'h00004; ta.lk = 1'b1;
        round(1'b1, 1'b0, ta, tz, 1);
        ta.lk = 1'b0;
        round(1'b1, 1'b1, ta, rand_txn(), 0);
        round(1'b1, 1'b1, rand_txn(), rand_txn(), 0);
`endif

        reset_mid();
        round(1'b1, 1'b1, rand_txn(), rand_txn(), 1);

        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            round(sel != 1, sel != 0, rand_txn(), rand_txn(), $urandom_range(0, 2));
        end

        repeat (6) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk("mem_low", 32'(pmem[20'(i)]), 32'(ref_rd(20'(i))));
        for (int i = 0; i < 16; i++)
            chk("mem_high", 32'(pmem[20'hFFFF0 + 20'(i)]), 32'(ref_rd(20'hFFFF0 + 20'(i))));
        chk("mem_12345", 32'(pmem[20'h12345]), 32'(ref_rd(20'h12345)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
